// File: rtl/regfile_mp_if.sv
// Bundle of decode/writeback signals for the multi-port register file.
// Sampled at clk_i rising edge: wr_en_i and iss_en_i qualify their address/data; reads are combinational.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
);
   localparam int AW = $clog2(DEPTH);

   logic [NREAD*AW-1:0]      rd_addr_i;
   logic [NREAD*DATA_W-1:0]  rd_data_o;
   logic [NREAD-1:0]         rd_busy_o;
   logic [NWRITE-1:0]        wr_en_i;
   logic [NWRITE*AW-1:0]     wr_addr_i;
   logic [NWRITE*DATA_W-1:0] wr_data_i;
   logic                     iss_en_i;
   logic [AW-1:0]            iss_addr_i;
   logic                     flush_i;

   modport master (
      output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, flush_i,
      input  rd_data_o, rd_busy_o
   );

   modport slave (
      input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, flush_i,
      output rd_data_o, rd_busy_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// hardwired zero register and a per-register busy scoreboard for RAW detection.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input logic           clk_i,
   input logic           rst_i,
   regfile_mp_if.slave   rf_if
);

   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [DATA_W-1:0]       mem_d [DEPTH];
   logic [DEPTH-1:0]        busy_q;
   logic [DEPTH-1:0]        busy_d;
   logic [NREAD*DATA_W-1:0] rd_data;
   logic [NREAD-1:0]        rd_busy;

   // Ascending port order makes the highest-index port the last writer.
   always_comb begin
      mem_d = mem_q;
      for (int p = 0; p < NWRITE; p++) begin
         if (rf_if.wr_en_i[p] &&
             !(ZERO_REG != 0 && rf_if.wr_addr_i[p*AW +: AW] == '0)) begin
            mem_d[rf_if.wr_addr_i[p*AW +: AW]] = rf_if.wr_data_i[p*DATA_W +: DATA_W];
         end
      end
   end

   // Writeback clears first so a same-cycle issue to that register wins.
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NWRITE; p++) begin
         if (rf_if.wr_en_i[p]) begin
            busy_d[rf_if.wr_addr_i[p*AW +: AW]] = 1'b0;
         end
      end
      if (rf_if.iss_en_i && !(ZERO_REG != 0 && rf_if.iss_addr_i == '0)) begin
         busy_d[rf_if.iss_addr_i] = 1'b1;
      end
      if (rf_if.flush_i) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q <= busy_d;
      end
   end

   // Read ports: storage, then forwarded write data, then the zero-register override.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NREAD; k++) begin
         rd_data[k*DATA_W +: DATA_W] = mem_q[rf_if.rd_addr_i[k*AW +: AW]];
         rd_busy[k]                  = busy_q[rf_if.rd_addr_i[k*AW +: AW]];
         if (BYPASS != 0) begin
            for (int p = 0; p < NWRITE; p++) begin
               if (rf_if.wr_en_i[p] &&
                   rf_if.wr_addr_i[p*AW +: AW] == rf_if.rd_addr_i[k*AW +: AW]) begin
                  rd_data[k*DATA_W +: DATA_W] = rf_if.wr_data_i[p*DATA_W +: DATA_W];
                  rd_busy[k]                  = 1'b0;
               end
            end
         end
         if (ZERO_REG != 0 && rf_if.rd_addr_i[k*AW +: AW] == '0) begin
            rd_data[k*DATA_W +: DATA_W] = '0;
            rd_busy[k]                  = 1'b0;
         end
      end
   end

   assign rf_if.rd_data_o = rd_data;
   assign rf_if.rd_busy_o = rd_busy;

endmodule
